// File: rtl/pi_fb_pkg.sv
// ---------------------------------------------------------------------------
// pi_fb_pkg
// Shared constants, clear-FSM state encoding and the framebuffer address
// packing helper for the Pi estimator plot framebuffer arbiter.
// ---------------------------------------------------------------------------
package pi_fb_pkg;

  localparam int FB_W     = 256;  // plot window width in pixels
  localparam int FB_H     = 256;  // plot window height in pixels
  localparam int FB_AW    = 16;   // framebuffer address width {row, col}
  localparam int PIPE_LAT = 3;    // display read latency, window pixel -> pix_on

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Framebuffer address layout: row in the upper byte, column in the lower.
  function automatic logic [FB_AW-1:0] pack_addr(input logic [7:0] y,
                                                 input logic [7:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/pi_fb_clear_seq.sv
// ---------------------------------------------------------------------------
// pi_fb_clear_seq
// Clear sequencer for the plot framebuffer. A clr_req pulse while idle walks
// a 16-bit address counter over the whole RAM, issuing one clear write on
// every cycle the shared port is free. Cycles where the display owns the port
// stall the counter. Requests arriving during a clear are ignored.
//
// Ports:
//   clk25     in   pixel clock
//   rst       in   synchronous active-high reset (aborts a running clear)
//   clr_req   in   start-clear pulse
//   port_free in   RAM port not claimed by the display this cycle
//   clr_busy  out  clear in progress
//   clr_we    out  issue a clear write this cycle (combinational)
//   clr_addr  out  address of the clear write
// ---------------------------------------------------------------------------
module pi_fb_clear_seq
  import pi_fb_pkg::*;
(
  input  logic             clk25,
  input  logic             rst,
  input  logic             clr_req,
  input  logic             port_free,
  output logic             clr_busy,
  output logic             clr_we,
  output logic [FB_AW-1:0] clr_addr
);

  clr_state_t       state, state_nx;
  logic [FB_AW-1:0] cnt, cnt_nx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, whatever the process order.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (port_free) begin
          clr_we = 1'b1;
          cnt_nx = cnt + 1'b1;
          // Write to the last address ends the clear on this edge.
          if (cnt == {FB_AW{1'b1}}) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/pi_fb_arbiter.sv
// ---------------------------------------------------------------------------
// pi_fb_arbiter
// Owns the single port of the 256x256 1-bpp plot framebuffer. The VGA scan
// reader has absolute priority inside the plot window; all other cycles are
// free and go to the clear sequencer first, then to the plot writer.
// Display path: window pixel in cycle t -> RAM read issued t+1 -> data t+2
// -> pix_on/pix_win registered in t+3.
//
// Optional build macro: PI_FB_WRCNT_EN adds wr_count[31:0], a saturating
// count of accepted plot writes, cleared by rst and by an accepted clr_req.
//
// Ports:
//   clk25, rst           pixel clock, synchronous active-high reset
//   px_x, px_y, vidSel   scan position and visible flag from timing generator
//   wr_valid/wr_ready    plot write handshake; wr_x, wr_y, wr_data payload
//   clr_req, clr_busy    start-clear pulse, clear in progress
//   mem_en/we/addr/wdata registered RAM port controls
//   mem_rdata            RAM read data, 1-cycle latency
//   pix_on, pix_win      plot pixel and window flag for display (3-cycle lag)
//   wr_count             (PI_FB_WRCNT_EN only) accepted plot write count
// ---------------------------------------------------------------------------
module pi_fb_arbiter
  import pi_fb_pkg::*;
#(
  parameter int   WIN_X0  = 192,
  parameter int   WIN_Y0  = 112,
  parameter logic CLR_VAL = 1'b0
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic [9:0]       px_x,
  input  logic [9:0]       px_y,
  input  logic             vidSel,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [7:0]       wr_y,
  input  logic             wr_data,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             mem_en,
  output logic             mem_we,
  output logic [FB_AW-1:0] mem_addr,
  output logic             mem_wdata,
  input  logic             mem_rdata,
  output logic             pix_on,
  output logic             pix_win
`ifdef PI_FB_WRCNT_EN
  ,
  output logic [31:0]      wr_count
`endif
);

  localparam logic [9:0] X_LO = 10'(WIN_X0);
  localparam logic [9:0] X_HI = 10'(WIN_X0 + FB_W);
  localparam logic [9:0] Y_LO = 10'(WIN_Y0);
  localparam logic [9:0] Y_HI = 10'(WIN_Y0 + FB_H);

  logic             win;
  logic [7:0]       rd_col, rd_row;
  logic             wr_fire;
  logic             clr_we;
  logic [FB_AW-1:0] clr_addr;
  logic             win_d1, win_d2;

  assign win = vidSel & (px_x >= X_LO) & (px_x < X_HI)
                      & (px_y >= Y_LO) & (px_y < Y_HI);

  // Offsets inside the window are 0..255, so 8-bit modular subtraction of the
  // low bytes gives the same result as the full-width difference.
  assign rd_col = px_x[7:0] - X_LO[7:0];
  assign rd_row = px_y[7:0] - Y_LO[7:0];

  assign wr_ready = ~rst & ~win & ~clr_busy;
  assign wr_fire  = wr_valid & wr_ready;

  pi_fb_clear_seq u_clear_seq (
    .clk25     (clk25),
    .rst       (rst),
    .clr_req   (clr_req),
    .port_free (~win),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // NOTE: only the port controls and the display pipeline are reset; the
  // framebuffer contents are not, and are re-initialised by a clear.
  always_ff @(posedge clk25) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 1'b0;
      win_d1    <= 1'b0;
      win_d2    <= 1'b0;
      pix_on    <= 1'b0;
      pix_win   <= 1'b0;
    end else begin
      win_d1  <= win;
      win_d2  <= win_d1;
      pix_win <= win_d2;
      // win_d2 marks the cycle in which mem_rdata belongs to a display read.
      pix_on  <= mem_rdata & win_d2;

      if (win) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= pack_addr(rd_row, rd_col);
      end else if (clr_we) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= clr_addr;
        mem_wdata <= CLR_VAL;
      end else if (wr_fire) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= pack_addr(wr_y, wr_x);
        mem_wdata <= wr_data;
      end else begin
        // Idle: address and data hold to avoid needless toggling.
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

`ifdef PI_FB_WRCNT_EN
  logic clr_start;
  assign clr_start = clr_req & ~clr_busy;

  always_ff @(posedge clk25) begin
    if (rst || clr_start) begin
      wr_count <= '0;
    end else if (wr_fire && (wr_count != 32'hFFFF_FFFF)) begin
      wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pi_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pi_fb_arbiter
// Directed self-checking bench for pi_fb_arbiter with a behavioural 64Kx1
// synchronous RAM. Inputs change 1 time unit after the rising edge; outputs
// are sampled there too, well away from the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pi_fb_arbiter;

  logic        clk25 = 1'b0;
  logic        rst;
  logic [9:0]  px_x, px_y;
  logic        vidSel;
  logic        wr_valid, wr_data, clr_req;
  logic [7:0]  wr_x, wr_y;
  logic        wr_ready, clr_busy, mem_en, mem_we, mem_wdata, pix_on, pix_win;
  logic [15:0] mem_addr;
  bit          rd_q;
`ifdef PI_FB_WRCNT_EN
  logic [31:0] wr_count;
`endif

  bit ram [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr, n_inwin, n_clr, n_other, exp_clr;

  pi_fb_arbiter dut (
    .clk25     (clk25),
    .rst       (rst),
    .px_x      (px_x),
    .px_y      (px_y),
    .vidSel    (vidSel),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (rd_q),
    .pix_on    (pix_on),
    .pix_win   (pix_win)
`ifdef PI_FB_WRCNT_EN
    ,
    .wr_count  (wr_count)
`endif
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference window for the default 192/112 origin.
  function automatic bit tb_win();
    return vidSel === 1'b1 && px_x >= 10'd192 && px_x < 10'd448 &&
           px_y >= 10'd112 && px_y < 10'd368;
  endfunction

  // Advance one clock: apply the RAM operation that was on the port during
  // the cycle just ended, then log the write (if any) newly on the port.
  task automatic tick();
    logic        s_en, s_we, s_wd;
    logic [15:0] s_addr;
    bit          s_win;
    s_en   = mem_en;
    s_we   = mem_we;
    s_wd   = mem_wdata;
    s_addr = mem_addr;
    s_win  = tb_win();
    @(posedge clk25);
    #1;
    if (s_en === 1'b1) begin
      if (s_we === 1'b1) ram[s_addr] = s_wd;
      else               rd_q = ram[s_addr];
    end
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      n_wr++;
      if (s_win) n_inwin++;
      if (mem_wdata === 1'b0 && int'(mem_addr) == exp_clr) begin
        n_clr++;
        exp_clr++;
      end else begin
        n_other++;
      end
    end
  endtask

  initial begin
    bit done;
    int c;

    rst = 1'b1; vidSel = 1'b0; px_x = '0; px_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0; clr_req = 1'b0;
    ram[16'h0005] = 1'b1;  // pixel (x=5, y=0)
    repeat (4) tick();
    rst = 1'b0;

    // ---- mid-frame reset: build up pipeline state, then reset 4 cycles ----
    vidSel = 1'b1; px_x = 10'd250; px_y = 10'd120;   // addr {8, 58} = 0x083A
    repeat (4) tick();
    check("pre_rst_addr", mem_addr, 32'h083A);
    check("pre_rst_pixwin", pix_win, 1);
    rst = 1'b1;
    repeat (4) tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pix_on", pix_on, 0);
    check("rst_pix_win", pix_win, 0);
    check("rst_clr_busy", clr_busy, 0);
    rst = 1'b0; vidSel = 1'b0;
    #1;
    check("rel_wr_ready", wr_ready, 1);
    tick();
    tick();
    check("rel_pix_win", pix_win, 0);

    // ---- window edges: just outside on each boundary -> port idle ----
    vidSel = 1'b1; px_x = 10'd191; px_y = 10'd112;
    #1 check("edge_x191_ready", wr_ready, 1);
    tick(); check("edge_x191_en", mem_en, 0);
    px_x = 10'd448; px_y = 10'd200;
    #1 check("edge_x448_ready", wr_ready, 1);
    tick(); check("edge_x448_en", mem_en, 0);
    px_x = 10'd300; px_y = 10'd368;
    tick(); check("edge_y368_en", mem_en, 0);
    px_x = 10'd300; px_y = 10'd111;
    tick(); check("edge_y111_en", mem_en, 0);
    vidSel = 1'b0; px_x = 10'd300; px_y = 10'd200;
    tick(); check("edge_novid_en", mem_en, 0);

`ifdef PI_FB_WRCNT_EN
    // ---- write counter: 1000 back-to-back accepted writes ----
    wr_valid = 1'b1; wr_data = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wr_x = 8'(i); wr_y = 8'(8'h80 + (i >> 8));
      tick();
    end
    wr_valid = 1'b0;
    check("wrcnt_1000", wr_count, 1000);
`endif

    // ---- display read sweep over one full window row ----
    for (int i = 0; i < 260; i++) begin
      if (i < 256) begin
        vidSel = 1'b1; px_x = 10'(192 + i); px_y = 10'd112;
      end else begin
        vidSel = 1'b0;
      end
      tick();
      if (i < 256) begin
        check("rd_en", mem_en, 1);
        check("rd_we", mem_we, 0);
        check("rd_addr", mem_addr, i);
      end
      check("rd_pix_on", pix_on, (i - 2 == 5) ? 1 : 0);
      check("rd_pix_win", pix_win, (i >= 2 && i < 258) ? 1 : 0);
    end

    // ---- write held across window cycles, accepted on first free cycle ----
    vidSel = 1'b1; px_x = 10'd200; px_y = 10'd150;
    wr_valid = 1'b1; wr_x = 8'h10; wr_y = 8'h20; wr_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("wa_blocked_ready", wr_ready, 0);
      tick();
      check("wa_blocked_we", mem_we, 0);
    end
    vidSel = 1'b0;
    #1 check("wa_free_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("wa_en", mem_en, 1);
    check("wa_we", mem_we, 1);
    check("wa_addr", mem_addr, 32'h2010);
    check("wa_wdata", mem_wdata, 1);
    tick();
    check("idle_en", mem_en, 0);
    check("idle_we", mem_we, 0);
    check("idle_addr_hold", mem_addr, 32'h2010);

    // ---- clr_req together with an accepted write ----
    wr_valid = 1'b1; wr_x = 8'h11; wr_y = 8'h20; wr_data = 1'b1; clr_req = 1'b1;
    #1 check("sim_ready", wr_ready, 1);
    tick();
    check("sim_we", mem_we, 1);
    check("sim_addr", mem_addr, 32'h2011);
    check("sim_wdata", mem_wdata, 1);
    check("sim_busy", clr_busy, 1);
    clr_req = 1'b0;
    wr_x = 8'h33; wr_y = 8'h44;   // new request stays pending during clear
    n_wr = 0; n_inwin = 0; n_clr = 0; n_other = 0; exp_clr = 0;

    // ---- full clear with periodic window bursts and a repeated clr_req ----
    done = 1'b0;
    c = 0;
    while (!done && c < 80000) begin
      if ((c % 1024) < 16) begin
        vidSel = 1'b1; px_x = 10'(192 + (c % 16)); px_y = 10'd112;
      end else begin
        vidSel = 1'b0;
      end
      clr_req = (c == 30000);
      if (c == 100) begin
        #1 check("clr_wr_stalled", wr_ready, 0);
      end
      tick();
      c++;
      if (clr_busy === 1'b0) done = 1'b1;
    end
    clr_req = 1'b0;
    check("clr_done", done, 1);
    check("clr_writes", n_clr, 65536);
    check("clr_other_writes", n_other, 0);
    check("clr_inwin_writes", n_inwin, 0);

    // pending write goes through once the clear has finished
    vidSel = 1'b0;
    #1 check("post_clr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("post_clr_we", mem_we, 1);
    check("post_clr_addr", mem_addr, 32'h4433);
    check("post_clr_wdata", mem_wdata, 1);

    // ---- reset in the middle of a clear ----
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("rc_busy", clr_busy, 1);
`ifdef PI_FB_WRCNT_EN
    check("wrcnt_clr", wr_count, 0);
`endif
    n_clr = 0; exp_clr = 0; n_other = 0;
    c = 0;
    while (n_clr < 32'h1234 && c < 6000) begin
      tick();
      c++;
    end
    check("rc_count", n_clr, 32'h1234);
    check("rc_other", n_other, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rc_busy_after_rst", clr_busy, 0);
    check("rc_en_after_rst", mem_en, 0);
    n_wr = 0;
    repeat (50) tick();
    check("rc_no_more_writes", n_wr, 0);
    check("rc_busy_stays_low", clr_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
